lmc_rx_cfg_ctrl: RTL and testbench
==================================

Name: lmc_rx_cfg_ctrl

Overview:
- Sequences rate (GEN) and link-width (LANESNUMBER) changes for the RX lane-management/unstriping datapath.
- Accepts a config request from the LTSSM and drains in-flight descrambler data while gating LMC output valid.
- Applies the new config, waits for the unstriping pipeline to settle, then acknowledges.
- Sits between LTSSM and LMC_RX; it is the only driver of the datapath's GEN/LANESNUMBER.

Parameters:
- DRAIN_IDLE_CYCLES, 4: consecutive cycles with all descramblerDataValid bits low that count as drained.
- SETTLE_CYCLES, 3: cycles the new config is held with output gated before release (covers unstriping + valid register latency).
- RESET_GEN, 1: GEN value after reset.
- RESET_LANES, 1: LANESNUMBER value after reset.
- TIMEOUT_CYCLES, 255: drain timeout, used only with LMC_CFG_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cfgReqValid  in  1  config change request
- cfgReqGen  in  3  requested rate, 1..5
- cfgReqLanes  in  5  requested width: 1, 2, 4, 8 or 16
- cfgReqReady  out  1  request accepted this cycle (valid&ready handshake)
- cfgDone  out  1  1-cycle pulse: new config active
- cfgErr  out  1  1-cycle pulse: request rejected, or drain timed out
- descramblerDataValid  in  16  per-lane valid from descrambler
- GEN  out  3  active rate to datapath
- LANESNUMBER  out  5  active width to datapath
- lmcHold  out  1  1 = downstream must mask LMCValid
- busy  out  1  state != RUN

Behaviour:
- Reset values: GEN=RESET_GEN, LANESNUMBER=RESET_LANES, state=RUN, cfgReqReady=1, lmcHold=0, cfgDone=0, cfgErr=0, busy=0. All counters are 0. Reset mid-sequence aborts immediately to these values.
- States: RUN, DRAIN, APPLY, SETTLE.
- RUN:
  - cfgReqReady=1. Handshake happens when cfgReqValid=1.
  - Validity check on the handshake cycle: gen in 1..5, and lanes one-hot with value ≤16.
  - Invalid request: cfgErr pulses the next cycle; stay in RUN; GEN and LANESNUMBER unchanged.
  - Valid request equal to the current config: cfgDone pulses the next cycle; stay in RUN; no hold.
  - Otherwise: latch pending gen/lanes, go to DRAIN, assert lmcHold from the next cycle.
- DRAIN:
  - cfgReqReady=0, lmcHold=1.
  - idleCnt increments while descramblerDataValid==0 and resets to 0 on any nonzero bit.
  - When idleCnt reaches DRAIN_IDLE_CYCLES-1 with the input still idle, go to APPLY.
- APPLY: single cycle. GEN and LANESNUMBER register the pending values (visible the next cycle). settleCnt clears. Go to SETTLE.
- SETTLE:
  - lmcHold=1. settleCnt counts to SETTLE_CYCLES-1.
  - Then cfgDone pulses, lmcHold deasserts in the same cycle, and the state returns to RUN.
  - cfgReqReady returns to 1 in the cycle after cfgDone.
- Latency for a valid change with idle input: handshake at cycle 0, DRAIN at 1..DRAIN_IDLE_CYCLES, APPLY, SETTLE, cfgDone at cycle DRAIN_IDLE_CYCLES+SETTLE_CYCLES+2.
- Requests raised while busy are not accepted; the requester holds cfgReqValid. They are never queued or dropped silently.
- GEN and LANESNUMBER change only in APPLY and never while lmcHold=0.
- Counters saturate and never wrap.
- cfgDone and cfgErr are mutually exclusive, except under timeout (see Optional Feature).

Optional Feature:
- LMC_CFG_TIMEOUT_EN defined:
  - A DRAIN watchdog counts cycles spent in DRAIN.
  - At TIMEOUT_CYCLES it forces APPLY and latches a sticky internal flag.
  - On completion, cfgErr and cfgDone pulse together.
- Undefined: no watchdog; DRAIN waits indefinitely for idle.

Decomposition:
- Shared package lmc_pkg:
  - state encoding constants (RUN=0, DRAIN=1, APPLY=2, SETTLE=3);
  - GEN range constants (GEN_MIN=1, GEN_MAX=5);
  - legal lane-count constants;
  - cfg_valid check function (gen, lanes).
- One natural sub-module, lmc_idle_counter: saturating consecutive-idle counter with threshold compare, reused for drain detection and the optional watchdog.

Test Plan:
- Reset mid-SETTLE (reset low for 1 cycle) → GEN=1, LANESNUMBER=1, lmcHold=0, cfgReqReady=1 the next cycle; no cfgDone.
- From reset, request gen=3, lanes=8 with descramblerDataValid=0 (defaults 4/3) → lmcHold high from cycle 1; GEN=3, LANESNUMBER=8 from cycle 6; cfgDone at cycle 9, when lmcHold drops.
- Same request with descramblerDataValid=16'h00FF for 10 cycles after the handshake → DRAIN holds; idleCnt restarts; cfgDone arrives 10 cycles later than with idle input.
- Request lanes=6, then gen=0, then gen=6 → cfgErr pulse for each; GEN/LANESNUMBER unchanged; lmcHold never asserts.
- Request equal to the current config (1,1) → cfgDone the next cycle; busy stays 0.
- With LMC_CFG_TIMEOUT_EN and TIMEOUT_CYCLES=20, descramblerDataValid stuck at 16'h0001 → APPLY entered after 20 DRAIN cycles; cfgErr and cfgDone pulse together; new config applied.

Source files
------------

// File: rtl/lmc_pkg.sv
// Shared types, constants and config legality check for the LMC RX config controller.
package lmc_pkg;

  localparam int unsigned GEN_W     = 3;
  localparam int unsigned LANES_W   = 5;
  localparam int unsigned NUM_LANES = 16;

  localparam int unsigned GEN_MIN = 1;
  localparam int unsigned GEN_MAX = 5;

  localparam logic [LANES_W-1:0] LANES_X1  = 5'd1;
  localparam logic [LANES_W-1:0] LANES_X2  = 5'd2;
  localparam logic [LANES_W-1:0] LANES_X4  = 5'd4;
  localparam logic [LANES_W-1:0] LANES_X8  = 5'd8;
  localparam logic [LANES_W-1:0] LANES_X16 = 5'd16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_APPLY  = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  typedef struct packed {
    logic [GEN_W-1:0]   gen;
    logic [LANES_W-1:0] lanes;
  } cfg_t;

  // Legal request: rate inside the supported range, width one of the legal lane counts.
  function automatic logic cfg_valid(input logic [GEN_W-1:0] gen, input logic [LANES_W-1:0] lanes);
    logic gen_ok;
    logic lanes_ok;
    gen_ok   = (gen >= GEN_W'(GEN_MIN)) && (gen <= GEN_W'(GEN_MAX));
    lanes_ok = (lanes == LANES_X1) || (lanes == LANES_X2) || (lanes == LANES_X4) ||
               (lanes == LANES_X8) || (lanes == LANES_X16);
    return gen_ok && lanes_ok;
  endfunction

endpackage

// File: rtl/lmc_idle_counter.sv
// Saturating consecutive-condition counter; hit_c flags the cycle that completes THRESH in a row.
module lmc_idle_counter #(
  parameter int unsigned THRESH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic cond_i,
  output logic hit_c
);

  localparam int unsigned        CNT_W = (THRESH > 1) ? $clog2(THRESH) : 1;
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0]   MAXV  = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count while the condition holds, restart on clear or a broken run, saturate at max.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !cond_i) begin
      cnt_d = '0;
    end else if (cnt_q != MAXV) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_c = !clr_i && cond_i && (cnt_q >= LAST);

endmodule

// File: rtl/lmc_rx_cfg_ctrl.sv
// Sequences GEN / LANESNUMBER changes for the LMC RX datapath: drain, apply, settle, acknowledge.
// Optional drain watchdog enabled by defining LMC_CFG_TIMEOUT_EN.
module lmc_rx_cfg_ctrl
  import lmc_pkg::*;
#(
  parameter int unsigned DRAIN_IDLE_CYCLES = 4,
  parameter int unsigned SETTLE_CYCLES     = 3,
  parameter int unsigned RESET_GEN         = 1,
  parameter int unsigned RESET_LANES       = 1
`ifdef LMC_CFG_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES    = 255
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfgReqValid,
  input  logic [GEN_W-1:0]     cfgReqGen,
  input  logic [LANES_W-1:0]   cfgReqLanes,
  output logic                 cfgReqReady,
  output logic                 cfgDone,
  output logic                 cfgErr,
  input  logic [NUM_LANES-1:0] descramblerDataValid,
  output logic [GEN_W-1:0]     GEN,
  output logic [LANES_W-1:0]   LANESNUMBER,
  output logic                 lmcHold,
  output logic                 busy
);

  localparam cfg_t RESET_CFG = '{gen: GEN_W'(RESET_GEN), lanes: LANES_W'(RESET_LANES)};

  state_e state_q, state_d;
  cfg_t   cur_q, cur_d;
  cfg_t   pend_q, pend_d;
  logic   ready_q, ready_d;
  logic   done_q, done_d;
  logic   err_q, err_d;
  logic   hold_q, hold_d;
  logic   busy_q, busy_d;
  logic   to_q, to_d;

  logic   idle_c;
  logic   hs_c;
  logic   drain_hit_c;
  logic   settle_hit_c;
  logic   wd_hit_c;
  cfg_t   req_c;

  assign idle_c = (descramblerDataValid == '0);
  assign hs_c   = cfgReqValid && ready_q;
  assign req_c  = '{gen: cfgReqGen, lanes: cfgReqLanes};

  // Consecutive idle cycles while draining.
  lmc_idle_counter #(.THRESH(DRAIN_IDLE_CYCLES)) u_drain_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (state_q != ST_DRAIN),
    .cond_i (idle_c),
    .hit_c  (drain_hit_c)
  );

  // Cycles spent holding the new config before release.
  lmc_idle_counter #(.THRESH(SETTLE_CYCLES)) u_settle_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (state_q != ST_SETTLE),
    .cond_i (1'b1),
    .hit_c  (settle_hit_c)
  );

`ifdef LMC_CFG_TIMEOUT_EN
  // Watchdog on total time spent draining.
  lmc_idle_counter #(.THRESH(TIMEOUT_CYCLES)) u_wd_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (state_q != ST_DRAIN),
    .cond_i (1'b1),
    .hit_c  (wd_hit_c)
  );
`else
  assign wd_hit_c = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    to_d    = to_q;
    unique case (state_q)
      ST_RUN: begin
        if (hs_c) begin
          if (!cfg_valid(req_c.gen, req_c.lanes)) begin
            err_d = 1'b1;
          end else if (req_c == cur_q) begin
            done_d = 1'b1;
          end else begin
            pend_d  = req_c;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_hit_c) begin
          state_d = ST_APPLY;
        end else if (wd_hit_c) begin
          state_d = ST_APPLY;
          to_d    = 1'b1;
        end
      end
      ST_APPLY: begin
        cur_d   = pend_q;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_hit_c) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
          err_d   = to_q;
          to_d    = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
    // Ready reopens one cycle after returning to RUN, so it never overlaps a cfgDone from SETTLE.
    ready_d = (state_q == ST_RUN) && (state_d == ST_RUN);
    hold_d  = (state_d != ST_RUN);
    busy_d  = (state_d != ST_RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cur_q   <= RESET_CFG;
      pend_q  <= RESET_CFG;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
    end
  end

  assign cfgReqReady = ready_q;
  assign cfgDone     = done_q;
  assign cfgErr      = err_q;
  assign GEN         = cur_q.gen;
  assign LANESNUMBER = cur_q.lanes;
  assign lmcHold     = hold_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_lmc_rx_cfg_ctrl.sv
// Scoreboard bench for lmc_rx_cfg_ctrl: a request-level model predicts each cfgDone/cfgErr.
module tb_lmc_rx_cfg_ctrl;

  localparam int D   = 4;
  localparam int S   = 3;
  localparam int LEN = 40;
`ifdef LMC_CFG_TIMEOUT_EN
  localparam int T   = 20;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfgReqValid = 1'b0;
  logic [2:0]  cfgReqGen = 3'd0;
  logic [4:0]  cfgReqLanes = 5'd0;
  logic        cfgReqReady, cfgDone, cfgErr, lmcHold, busy;
  logic [15:0] descramblerDataValid = 16'h0;
  logic [2:0]  GEN;
  logic [4:0]  LANESNUMBER;

`ifdef LMC_CFG_TIMEOUT_EN
  lmc_rx_cfg_ctrl #(.TIMEOUT_CYCLES(T)) dut (
`else
  lmc_rx_cfg_ctrl dut (
`endif
    .clk(clk), .reset(reset), .cfgReqValid(cfgReqValid), .cfgReqGen(cfgReqGen),
    .cfgReqLanes(cfgReqLanes), .cfgReqReady(cfgReqReady), .cfgDone(cfgDone), .cfgErr(cfgErr),
    .descramblerDataValid(descramblerDataValid), .GEN(GEN), .LANESNUMBER(LANESNUMBER),
    .lmcHold(lmcHold), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit done;
    bit err;
    int gen;
    int lanes;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          cur_gen = 1;
  int          cur_lanes = 1;
  logic [15:0] pat [0:LEN];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit legal(input int g, input int l);
    return (g >= 1) && (g <= 5) && (l == 1 || l == 2 || l == 4 || l == 8 || l == 16);
  endfunction

  // First drain cycle (1-based after the handshake) that closes a run of D idle cycles.
  function automatic int drain_end();
    for (int k = D; k <= LEN; k++) begin
      bit ok = 1'b1;
      for (int j = k - D + 1; j <= k; j++) if (pat[j] != 16'h0) ok = 1'b0;
      if (ok) return k;
    end
    return LEN + 1000;
  endfunction

  task automatic fill_idle();
    for (int i = 0; i <= LEN; i++) pat[i] = 16'h0;
  endtask

  task automatic fill_busy(input int b, input logic [15:0] v);
    for (int i = 0; i <= LEN; i++) pat[i] = (i >= 1 && i <= b) ? v : 16'h0;
  endtask

  task automatic fill_sparse();
    for (int i = 0; i <= LEN; i++)
      pat[i] = (i >= 1 && i <= 20 && $urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0;
  endtask

  // Issue one request, predict its response, and drive the descrambler pattern while it runs.
  task automatic do_req(input int g, input int l, input bit probe);
    int  n = 0;
    int  h, k, og, ol;
    bit  change, terr;
    @(negedge clk);
    while (cfgReqReady !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(n < 200), 1);
    cfgReqValid = 1'b1;
    cfgReqGen   = 3'(g);
    cfgReqLanes = 5'(l);
    h  = cyc;
    og = cur_gen;
    ol = cur_lanes;
    change = 1'b0;
    if (!legal(g, l)) begin
      q.push_back('{cyc: h + 1, done: 1'b0, err: 1'b1, gen: og, lanes: ol});
    end else if (g == og && l == ol) begin
      q.push_back('{cyc: h + 1, done: 1'b1, err: 1'b0, gen: og, lanes: ol});
    end else begin
      change = 1'b1;
      k = drain_end();
      terr = 1'b0;
`ifdef LMC_CFG_TIMEOUT_EN
      if (k > T) begin
        k = T;
        terr = 1'b1;
      end
`endif
      q.push_back('{cyc: h + k + S + 2, done: 1'b1, err: terr, gen: g, lanes: l});
      cur_gen = g;
      cur_lanes = l;
    end
    @(negedge clk);
    cfgReqValid = 1'b0;
    if (!change) begin
      chk("no_hold_after_immediate", lmcHold, 0);
      chk("not_busy_after_immediate", busy, 0);
    end else begin
      for (int i = 1; i <= LEN; i++) begin
        if (probe && i == 1) begin
          chk("hold_cycle1", lmcHold, 1);
          chk("ready_low_cycle1", cfgReqReady, 0);
          chk("busy_cycle1", busy, 1);
        end
        if (probe && i == 5) chk("gen_old_in_apply", GEN, og);
        if (probe && i == 6) begin
          chk("gen_new_cycle6", GEN, g);
          chk("lanes_new_cycle6", LANESNUMBER, l);
        end
        descramblerDataValid = pat[i];
        @(negedge clk);
      end
      descramblerDataValid = 16'h0;
    end
  endtask

  // Monitor: pop and compare on every cfgDone/cfgErr, flag overdue or unexpected responses.
  bit         prev_ok = 1'b0;
  logic [2:0] prev_gen;
  logic [4:0] prev_lanes;
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      if (prev_ok && (GEN !== prev_gen || LANESNUMBER !== prev_lanes))
        chk("cfg_change_needs_hold", lmcHold, 1);
      if (cfgDone === 1'b1 || cfgErr === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_response", {cfgDone, cfgErr}, 0);
        end else begin
          e = q.pop_front();
          chk("resp_cycle", cyc, e.cyc);
          chk("resp_done", cfgDone, e.done);
          chk("resp_err", cfgErr, e.err);
          chk("resp_gen", GEN, e.gen);
          chk("resp_lanes", LANESNUMBER, e.lanes);
          chk("resp_hold_low", lmcHold, 0);
        end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        e = q.pop_front();
        chk("response_missing", cyc, e.cyc);
      end
      prev_ok = 1'b1;
    end else begin
      prev_ok = 1'b0;
    end
    prev_gen   = GEN;
    prev_lanes = LANESNUMBER;
  end

  initial begin
    int h;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", cfgReqReady, 1);
    chk("rst_hold", lmcHold, 0);
    chk("rst_done", cfgDone, 0);
    chk("rst_err", cfgErr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gen", GEN, 1);
    chk("rst_lanes", LANESNUMBER, 1);

    // Idle-input change from reset with cycle-accurate probes.
    fill_idle();
    do_req(3, 8, 1'b1);

    // Reset in the middle of SETTLE aborts without a cfgDone.
    @(negedge clk);
    while (cfgReqReady !== 1'b1) @(negedge clk);
    cfgReqValid = 1'b1;
    cfgReqGen   = 3'd2;
    cfgReqLanes = 5'd4;
    h = cyc;
    @(negedge clk);
    cfgReqValid = 1'b0;
    repeat (6) @(negedge clk);
    chk("settle_busy", busy, 1);
    chk("settle_gen", GEN, 2);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_gen", GEN, 1);
    chk("abort_lanes", LANESNUMBER, 1);
    chk("abort_hold", lmcHold, 0);
    chk("abort_ready", cfgReqReady, 1);
    chk("abort_cycle", cyc, h + 9);
    cur_gen = 1;
    cur_lanes = 1;

    // Busy descrambler for 10 cycles delays completion by 10.
    fill_busy(10, 16'h00FF);
    do_req(3, 8, 1'b0);

    // Illegal requests and a no-op request.
    do_req(1, 6, 1'b0);
    do_req(0, 8, 1'b0);
    do_req(6, 8, 1'b0);
    do_req(3, 8, 1'b0);

`ifdef LMC_CFG_TIMEOUT_EN
    fill_busy(LEN, 16'h0001);
    do_req(4, 2, 1'b0);
`endif

    // Randomized requests and drain patterns.
    for (int it = 0; it < 25; it++) begin
      int g, l, mode;
      int lt[5] = '{1, 2, 4, 8, 16};
      g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 5));
      l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : lt[$urandom_range(0, 4)];
      mode = $urandom_range(0, 2);
      if (mode == 0) fill_idle();
      else if (mode == 1) fill_busy($urandom_range(1, 12), 16'($urandom_range(1, 65535)));
      else fill_sparse();
      do_req(g, l, 1'b0);
    end

    repeat (50) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
